// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the 16x24 register file: load returns take the write port first,
// then queued ALU results, then a same-cycle ALU bypass. Also keeps a busy scoreboard for decode.
module regfile_wb_arbiter #(
  parameter int WIDTH        = 24,
  parameter int REGNUM       = 16,
  parameter int ADDRESSWIDTH = 4,
  parameter int DEPTH        = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [ADDRESSWIDTH-1:0] alu_wa,
  input  logic [WIDTH-1:0]        alu_wd,
  input  logic                    ld_issue,
  input  logic [ADDRESSWIDTH-1:0] ld_issue_wa,
  input  logic                    ld_valid,
  input  logic [ADDRESSWIDTH-1:0] ld_wa,
  input  logic [WIDTH-1:0]        ld_wd,
  output logic                    we3,
  output logic [ADDRESSWIDTH-1:0] wa3,
  output logic [WIDTH-1:0]        wd3,
  output logic [REGNUM-1:0]       busy,
  output logic                    err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDRESSWIDTH-1:0] PC_REG = ADDRESSWIDTH'(REGNUM - 1);

  logic [ADDRESSWIDTH-1:0] fifo_wa_q [DEPTH];
  logic [WIDTH-1:0]        fifo_wd_q [DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [REGNUM-1:0]       pend_q, pend_d;
  logic                    err_q, err_d;
  logic                    alu_valid_prev_q, alu_ready_prev_q;
  logic                    we3_q, we3_d;
  logic [ADDRESSWIDTH-1:0] wa3_q, wa3_d;
  logic [WIDTH-1:0]        wd3_q, wd3_d;

  logic accept, alu_keep, ld_keep, fifo_empty, pop, bypass, push;
  logic [DEPTH-1:0] live;

  assign alu_ready  = (count_q < CW'(DEPTH));
  assign accept     = alu_valid & alu_ready;
  assign alu_keep   = accept & (alu_wa != PC_REG);
  assign ld_keep    = ld_valid & (ld_wa != PC_REG);
  assign fifo_empty = (count_q == '0);
  assign pop        = ~ld_keep & ~fifo_empty;
  assign bypass     = ~ld_keep & fifo_empty & alu_keep;
  assign push       = alu_keep & ~bypass;

  // An entry is live when its distance from the read pointer is below the count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      logic [PW-1:0] offset;
      assign offset   = PW'(gi) - rd_ptr_q;
      assign live[gi] = ({1'b0, offset} < count_q);
    end
  endgenerate

  always_comb begin
    busy = pend_q;
    for (int e = 0; e < DEPTH; e++) begin
      if (live[e]) busy[fifo_wa_q[e]] = 1'b1;
    end
    busy[REGNUM-1] = 1'b0;
  end

  always_comb begin
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (ld_keep) begin
      we3_d = 1'b1;
      wa3_d = ld_wa;
      wd3_d = ld_wd;
    end else if (pop) begin
      we3_d = 1'b1;
      wa3_d = fifo_wa_q[rd_ptr_q];
      wd3_d = fifo_wd_q[rd_ptr_q];
    end else if (bypass) begin
      we3_d = 1'b1;
      wa3_d = alu_wa;
      wd3_d = alu_wd;
    end
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
  end

  // Return clears before issue sets, so a same-cycle reissue keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (ld_valid) pend_d[ld_wa] = 1'b0;
    if (ld_issue) pend_d[ld_issue_wa] = 1'b1;
    err_d = err_q
          | (ld_issue & pend_q[ld_issue_wa] & ~(ld_valid & (ld_wa == ld_issue_wa)))
          | (ld_valid & ~pend_q[ld_wa])
          | (alu_valid_prev_q & ~alu_ready_prev_q & ~alu_valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      pend_q           <= '0;
      err_q            <= 1'b0;
      alu_valid_prev_q <= 1'b0;
      alu_ready_prev_q <= 1'b0;
      we3_q            <= 1'b0;
      wa3_q            <= '0;
      wd3_q            <= '0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      pend_q           <= pend_d;
      err_q            <= err_d;
      alu_valid_prev_q <= alu_valid;
      alu_ready_prev_q <= alu_ready;
      we3_q            <= we3_d;
      wa3_q            <= wa3_d;
      wd3_q            <= wd3_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_wa_q[wr_ptr_q] <= alu_wa;
      fifo_wd_q[wr_ptr_q] <= alu_wd;
    end
  end

  assign we3 = we3_q;
  assign wa3 = wa3_q;
  assign wd3 = wd3_q;
  assign err = err_q;

endmodule
